// File: rtl/an_n29_pkg.sv
// Shared constants, payload types and the residue->syndrome table for the A=29 AN-code corrector.
package an_n29_pkg;

    localparam int unsigned A     = 29;
    localparam int unsigned CW_W  = 14;
    localparam int unsigned Q_W   = 10;
    localparam int unsigned R_W   = 5;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned K_W   = 10;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned SYN_N = A - 1;

    // One syndrome: flipped bit position, error sign, quotient offset k
    typedef struct packed {
        logic [IDX_W-1:0]      idx;
        logic                  neg;
        logic signed [K_W-1:0] k;
    } syn_entry_t;

    typedef struct packed {
        logic [Q_W-1:0]        q;
        logic                  error;
        logic                  consistent;
        logic signed [K_W-1:0] k;
    } s1_payload_t;

    typedef struct packed {
        logic [Q_W-1:0] q;
        logic           corrected;
        logic           uncorr;
    } s2_payload_t;

    // Entry n holds residue n+1; e=+2^i gives k=floor(2^i/29), e=-2^i gives k=-ceil(2^i/29)
    localparam syn_entry_t SYN_TABLE [SYN_N] = '{
        '{4'd0,  1'b0,  10'sd0},    // r=1
        '{4'd1,  1'b0,  10'sd0},    // r=2
        '{4'd5,  1'b0,  10'sd1},    // r=3
        '{4'd2,  1'b0,  10'sd0},    // r=4
        '{4'd8,  1'b1, -10'sd9},    // r=5
        '{4'd6,  1'b0,  10'sd2},    // r=6
        '{4'd12, 1'b0,  10'sd141},  // r=7
        '{4'd3,  1'b0,  10'sd0},    // r=8
        '{4'd10, 1'b0,  10'sd35},   // r=9
        '{4'd9,  1'b1, -10'sd18},   // r=10
        '{4'd11, 1'b1, -10'sd71},   // r=11
        '{4'd7,  1'b0,  10'sd4},    // r=12
        '{4'd4,  1'b1, -10'sd1},    // r=13
        '{4'd13, 1'b0,  10'sd282},  // r=14
        '{4'd13, 1'b1, -10'sd283},  // r=15
        '{4'd4,  1'b0,  10'sd0},    // r=16
        '{4'd7,  1'b1, -10'sd5},    // r=17
        '{4'd11, 1'b0,  10'sd70},   // r=18
        '{4'd9,  1'b0,  10'sd17},   // r=19
        '{4'd10, 1'b1, -10'sd36},   // r=20
        '{4'd3,  1'b1, -10'sd1},    // r=21
        '{4'd12, 1'b1, -10'sd142},  // r=22
        '{4'd6,  1'b1, -10'sd3},    // r=23
        '{4'd8,  1'b0,  10'sd8},    // r=24
        '{4'd2,  1'b1, -10'sd1},    // r=25
        '{4'd5,  1'b1, -10'sd2},    // r=26
        '{4'd1,  1'b1, -10'sd1},    // r=27
        '{4'd0,  1'b1, -10'sd1}     // r=28
    };

    // Apply q-k in Q_W+2 signed bits; out-of-range or inconsistent errors pass q through
    function automatic s2_payload_t correct(input s1_payload_t p);
        logic signed [Q_W+1:0] diff;
        s2_payload_t           o;
        o.q         = p.q;
        o.corrected = 1'b0;
        o.uncorr    = 1'b0;
        diff = $signed({2'b00, p.q}) - $signed({{(Q_W+2-K_W){p.k[K_W-1]}}, p.k});
        if (p.error) begin
            if (p.consistent && (diff[Q_W+1:Q_W] == 2'b00)) begin
                o.q         = diff[Q_W-1:0];
                o.corrected = 1'b1;
            end else begin
                o.uncorr = 1'b1;
            end
        end
        return o;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/an_syndrome_rom_n29.sv
// Combinational residue -> syndrome lookup; hit_o is low for r=0 and for illegal r>=29.
module an_syndrome_rom_n29
    import an_n29_pkg::*;
(
    input  logic [R_W-1:0] r_i,
    output syn_entry_t     entry_o,
    output logic           hit_o
);

    always_comb begin
        entry_o = '0;
        hit_o   = 1'b0;
        if ((r_i != '0) && (r_i < R_W'(A))) begin
            hit_o   = 1'b1;
            entry_o = SYN_TABLE[r_i - R_W'(1)];
        end
    end

endmodule

// File: rtl/an_corrector_n29.sv
// Two-stage valid/ready single-bit AN-code (A=29) corrector after the Barrett decoder.
// Optional AN_STATS_EN adds saturating corrected/uncorrectable beat counters.
module an_corrector_n29
    import an_n29_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW_W-1:0]  in_codeword,
    input  logic [Q_W-1:0]   in_q,
    input  logic [R_W-1:0]   in_r,
    input  logic             in_error,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Q_W-1:0]   out_q,
    output logic             out_corrected,
    output logic             out_uncorr,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_corr_cnt,
    output logic [CNT_W-1:0] stat_unc_cnt
);

    syn_entry_t  syn;
    logic        syn_hit;
    s1_payload_t s1_q, s1_d;
    s2_payload_t s2_q, s2_d;
    logic        s1_valid_q, s2_valid_q;
    logic        s1_load, s2_load;

    an_syndrome_rom_n29 u_rom (
        .r_i     (in_r),
        .entry_o (syn),
        .hit_o   (syn_hit)
    );

    // A stage may load when empty or when its contents move downstream this cycle
    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    // Illegal residues are forced to errors; syn_hit=0 then makes them inconsistent
    always_comb begin
        s1_d.q          = in_q;
        s1_d.error      = in_error || (in_r >= R_W'(A));
        s1_d.consistent = syn_hit && (in_codeword[syn.idx] ^ syn.neg);
        s1_d.k          = syn.k;
    end

    assign s2_d = correct(s1_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
        end else begin
            if (s1_load) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                end
            end
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_q <= s2_d;
                end
            end
        end
    end

    assign out_valid     = s2_valid_q;
    assign out_q         = s2_q.q;
    assign out_corrected = s2_q.corrected;
    assign out_uncorr    = s2_q.uncorr;

`ifdef AN_STATS_EN
    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] unc_cnt_q, unc_cnt_d;
    logic             out_fire;

    assign out_fire = s2_valid_q && out_ready;

    // Clear wins over a same-cycle increment
    always_comb begin
        corr_cnt_d = corr_cnt_q;
        unc_cnt_d  = unc_cnt_q;
        if (stat_clr) begin
            corr_cnt_d = '0;
            unc_cnt_d  = '0;
        end else if (out_fire) begin
            if (s2_q.corrected) begin
                corr_cnt_d = sat_inc(corr_cnt_q);
            end
            if (s2_q.uncorr) begin
                unc_cnt_d = sat_inc(unc_cnt_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            corr_cnt_q <= '0;
            unc_cnt_q  <= '0;
        end else begin
            corr_cnt_q <= corr_cnt_d;
            unc_cnt_q  <= unc_cnt_d;
        end
    end

    assign stat_corr_cnt = corr_cnt_q;
    assign stat_unc_cnt  = unc_cnt_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_corr_cnt   = '0;
    assign stat_unc_cnt    = '0;
`endif

endmodule
